// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel and the
// decoder-facing instruction handshake.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: credit-limited in-order word fetch into a prefetch FIFO,
// with redirect flush, stale-response discard and sticky misalignment halt.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_unit_if.master    bus,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  fetch_err
);

  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0]   ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [31:0]   pc_r, pc_s;
  logic [31:0]   rsp_pc_r, rsp_pc_s;
  logic [CW-1:0] out_r, out_s;
  logic [CW-1:0] disc_r, disc_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          err_r, err_s;
  logic [31:0]   fifo_instr_r [FIFO_DEPTH];
  logic [31:0]   fifo_instr_s [FIFO_DEPTH];
  logic [31:0]   fifo_pc_r    [FIFO_DEPTH];
  logic [31:0]   fifo_pc_s    [FIFO_DEPTH];
  logic          req_valid_s, req_fire_s, rsp_ok_s, push_s, pop_s;
  logic [CW-1:0] wr_idx_s;

  // Stale in-flight requests keep consuming credit until their responses return.
  assign req_valid_s = (state_r == ST_FETCH) &&
                       (({1'b0, out_r} + {1'b0, cnt_r}) < DEPTH_C);
  assign req_fire_s  = req_valid_s & bus.imem_req_ready;
  assign rsp_ok_s    = bus.imem_rsp_valid & (out_r != ZERO_C);
  assign pop_s       = (cnt_r != ZERO_C) & bus.dec_ready;

  assign bus.imem_req_valid = rst_n & req_valid_s;
  assign bus.imem_req_addr  = rst_n ? pc_r : 32'h0000_0000;
  assign bus.dec_valid      = (cnt_r != ZERO_C);
  assign bus.dec_instr      = fifo_instr_r[0];
  assign bus.dec_pc         = fifo_pc_r[0];
  assign fetch_err          = err_r;

  // Next-state for PC, credit/discard counters, FIFO occupancy and FSM.
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    rsp_pc_s = rsp_pc_r;
    disc_s   = disc_r;
    cnt_s    = cnt_r;
    err_s    = err_r;
    push_s   = 1'b0;
    out_s    = out_r + (req_fire_s ? ONE_C : ZERO_C) - (rsp_ok_s ? ONE_C : ZERO_C);
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      pc_s     = redirect_pc;
      rsp_pc_s = redirect_pc;
      cnt_s    = ZERO_C;
      disc_s   = out_s;
      if (redirect_pc[1:0] != 2'b00) begin
        state_s = ST_HALT;
        err_s   = 1'b1;
      end else begin
        state_s = ST_FETCH;
        err_s   = err_r;
      end
    end else begin
      pc_s = req_fire_s ? (pc_r + 32'd4) : pc_r;
      if (rsp_ok_s && (disc_r != ZERO_C)) begin
        disc_s = disc_r - ONE_C;
      end else if (rsp_ok_s) begin
        push_s   = 1'b1;
        rsp_pc_s = rsp_pc_r + 32'd4;
      end else begin
        disc_s = disc_r;
      end
      cnt_s = cnt_r + (push_s ? ONE_C : ZERO_C) - (pop_s ? ONE_C : ZERO_C);
    end
  end

  // Shift-style FIFO so the head entry is always a flop feeding the decoder.
  always_comb begin
    wr_idx_s = cnt_r - (pop_s ? ONE_C : ZERO_C);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (push_s && (wr_idx_s == CW'(i))) begin
        fifo_instr_s[i] = bus.imem_rsp_data;
        fifo_pc_s[i]    = rsp_pc_r;
      end else if (pop_s && (i < FIFO_DEPTH - 1)) begin
        fifo_instr_s[i] = fifo_instr_r[(i + 1) % FIFO_DEPTH];
        fifo_pc_s[i]    = fifo_pc_r[(i + 1) % FIFO_DEPTH];
      end else begin
        fifo_instr_s[i] = fifo_instr_r[i];
        fifo_pc_s[i]    = fifo_pc_r[i];
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_FETCH;
      pc_r     <= RESET_PC;
      rsp_pc_r <= RESET_PC;
      out_r    <= ZERO_C;
      disc_r   <= ZERO_C;
      cnt_r    <= ZERO_C;
      err_r    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_r[i] <= 32'h0000_0000;
        fifo_pc_r[i]    <= 32'h0000_0000;
      end
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      rsp_pc_r     <= rsp_pc_s;
      out_r        <= out_s;
      disc_r       <= disc_s;
      cnt_r        <= cnt_s;
      err_r        <= err_s;
      fifo_instr_r <= fifo_instr_s;
      fifo_pc_r    <= fifo_pc_s;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory latency/backpressure against a
// transaction-level model of the expected fetch and delivery streams.
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        mq[$];
  int          m_buf;
  logic [31:0] m_req_pc, m_dec_pc;
  bit          m_halt, m_err;
  int          cyc;
  int          n_pass, n_total;
  int          lat_min, lat_max, ready_pct, dec_pct, rsp_pct;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic bit chance(input int pct);
    return ($urandom_range(99, 0) < pct);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    mq.delete();
    m_buf    = 0;
    m_req_pc = 32'h0;
    m_dec_pc = 32'h0;
    m_halt   = 1'b0;
    m_err    = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check at negedge+1, advance the model.
  task automatic step(input bit rv, input logic [31:0] rpc);
    bit   exp_rv, ready, rsp, drdy, hs, pp;
    req_t h;
    cyc++;
    ready = chance(ready_pct);
    drdy  = chance(dec_pct);
    rsp   = (mq.size() > 0) && (mq[0].due <= cyc) && chance(rsp_pct);
    bus.imem_req_ready = ready;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(mq[0].addr) : $urandom();
    bus.dec_ready      = drdy;
    redirect_valid     = rv;
    redirect_pc        = rpc;
    #1;
    exp_rv = !m_halt && ((mq.size() + m_buf) < DEPTH);
    check("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) check("req_addr", bus.imem_req_addr, m_req_pc);
    check("dec_valid", {31'b0, bus.dec_valid}, {31'b0, (m_buf > 0)});
    if (m_buf > 0) begin
      check("dec_pc", bus.dec_pc, m_dec_pc);
      check("dec_instr", bus.dec_instr, mem_word(m_dec_pc));
    end
    check("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    hs = exp_rv && ready;
    pp = (m_buf > 0) && drdy;
    if (rsp) begin
      h = mq.pop_front();
      if (!h.stale && !rv) m_buf++;
    end
    if (pp && !rv) begin
      m_buf--;
      m_dec_pc += 32'd4;
    end
    if (hs) begin
      mq.push_back('{m_req_pc, cyc + int'($urandom_range(lat_max, lat_min)), 1'b0});
      m_req_pc += 32'd4;
    end
    if (rv) begin
      m_buf = 0;
      foreach (mq[i]) mq[i].stale = 1'b1;
      m_req_pc = rpc;
      m_dec_pc = rpc;
      m_halt   = (rpc[1:0] != 2'b00);
      if (m_halt) m_err = 1'b1;
    end
    @(negedge clk);
  endtask

  // Runs with dec_ready held high until the head is valid, then checks its PC.
  task automatic wait_dec(input string tag, input logic [31:0] exp_pc);
    for (int k = 0; k < 30 && !bus.dec_valid; k++) step(1'b0, 32'h0);
    check({tag, "_valid"}, {31'b0, bus.dec_valid}, 32'h1);
    check(tag, bus.dec_pc, exp_pc);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req_valid"}, {31'b0, bus.imem_req_valid}, 32'h0);
    check({tag, "_req_addr"}, bus.imem_req_addr, 32'h0);
    check({tag, "_dec_valid"}, {31'b0, bus.dec_valid}, 32'h0);
    check({tag, "_fetch_err"}, {31'b0, fetch_err}, 32'h0);
  endtask

  initial begin
    logic [31:0] rt;
    n_pass = 0; n_total = 0; cyc = 0;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0; bus.dec_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;

    // Streaming at 1-cycle latency.
    lat_min = 1; lat_max = 1; ready_pct = 100; dec_pct = 100; rsp_pct = 100;
    repeat (20) step(1'b0, 32'h0);

    // Decoder stall fills the credit window, then resumes.
    dec_pct = 0;
    repeat (10) step(1'b0, 32'h0);
    check("stall_head_pc", bus.dec_pc, m_dec_pc);
    dec_pct = 100;
    repeat (10) step(1'b0, 32'h0);

    // Redirect with two requests outstanding at 3-cycle latency.
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && mq.size() != 2; k++) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0100);
    wait_dec("t3_first_pc", 32'h0000_0100);
    repeat (6) step(1'b0, 32'h0);

    // Redirect coinciding with response + pop, then with handshake + pop.
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 20 && !(mq.size() == 1 && m_buf == 1); k++) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0400);
    wait_dec("t4a_first_pc", 32'h0000_0400);
    for (int k = 0; k < 20 && !(mq.size() == 0 && m_buf == 1); k++) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0800);
    wait_dec("t4b_first_pc", 32'h0000_0800);

    // Misaligned redirect halts; aligned redirect resumes, error stays.
    step(1'b1, 32'h0000_0102);
    repeat (8) step(1'b0, 32'h0);
    check("t5_err_set", {31'b0, fetch_err}, 32'h1);
    check("t5_halt_noreq", {31'b0, bus.imem_req_valid}, 32'h0);
    step(1'b1, 32'h0000_0200);
    wait_dec("t5_resume_pc", 32'h0000_0200);
    check("t5_err_sticky", {31'b0, fetch_err}, 32'h1);

    // Address wrap.
    step(1'b1, 32'hFFFF_FFFC);
    wait_dec("t6_top_pc", 32'hFFFF_FFFC);
    step(1'b0, 32'h0);
    wait_dec("t6_wrap_pc", 32'h0000_0000);

    // Randomized traffic with random redirects.
    lat_min = 1; lat_max = 4; ready_pct = 70; dec_pct = 60; rsp_pct = 70;
    for (int k = 0; k < 600; k++) begin
      if (chance(5)) begin
        rt = {22'h0, 8'($urandom_range(255, 0)), 2'b00};
        if (chance(12)) rt[1:0] = 2'($urandom_range(3, 1));
        if (chance(10)) rt = 32'hFFFF_FFF8;
        step(1'b1, rt);
      end else begin
        step(1'b0, 32'h0);
      end
    end

    // Reset in the middle of traffic with the error flag set.
    step(1'b1, 32'h0000_0003);
    step(1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    model_reset();
    bus.imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lat_min = 1; lat_max = 2; ready_pct = 100; dec_pct = 100; rsp_pct = 100;
    wait_dec("midrst_first_pc", 32'h0000_0000);
    repeat (10) step(1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
